// File: rtl/stone_ram_arbiter.sv
// Serialises drawer and rope access to the single-port stone RAM,
// with an atomic test-and-set that lets exactly one rope claim a stone.
module stone_ram_arbiter #(
  parameter int DRAW_MAX_CONSEC = 4,
  parameter int RAM_LATENCY     = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  quantity,
  input  logic        draw_req,
  input  logic [3:0]  draw_addr,
  output logic        draw_ack,
  input  logic [1:0]  rope_req,
  input  logic [3:0]  rope_op,
  input  logic [7:0]  rope_addr,
  input  logic [63:0] rope_wdata,
  output logic [1:0]  rope_ack,
  output logic [31:0] rdata,
  output logic        tas_ok,
  output logic        busy,
  output logic [3:0]  ram_address,
  output logic [31:0] ram_data,
  output logic        ram_wren,
  input  logic [31:0] ram_q
);

  localparam int SW = $clog2(DRAW_MAX_CONSEC + 1);
  localparam logic [SW-1:0] SMAX = SW'(DRAW_MAX_CONSEC);
  localparam logic [1:0] CNT_LAST = 2'(RAM_LATENCY - 1);

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_TAS = 2'b10;

  localparam logic [1:0] W_DRAW = 2'd0;
  localparam logic [1:0] W_R0   = 2'd1;
  localparam logic [1:0] W_R1   = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_TAS_WR,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    who_q, who_d;
  logic [1:0]    op_q, op_d;
  logic [3:0]    addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   word_q, word_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          rr_last_q, rr_last_d;

  logic          draw_ack_q, draw_ack_d;
  logic [1:0]    rope_ack_q, rope_ack_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          tas_ok_q, tas_ok_d;
  logic          busy_q, busy_d;
  logic [3:0]    ram_address_q, ram_address_d;
  logic [31:0]   ram_data_q, ram_data_d;
  logic          ram_wren_q, ram_wren_d;

  logic          rope_any;
  logic          draw_wins;
  logic          pick;
  logic          grant;
  logic [1:0]    g_who;
  logic [1:0]    g_op;
  logic [1:0]    g_raw_op;
  logic [3:0]    g_addr;
  logic [31:0]   g_wdata;
  logic [31:0]   res;
  logic          res_ok;

  // Arbitration for the IDLE decision
  always_comb begin
    rope_any  = |rope_req;
    draw_wins = draw_req && !((streak_q == SMAX) && rope_any);
    pick      = 1'b0;
    if (rope_req == 2'b11) begin
      pick = ~rr_last_q;
    end else begin
      pick = rope_req[1];
    end
    grant    = draw_wins || rope_any;
    g_who    = W_DRAW;
    g_op     = OP_RD;
    g_raw_op = OP_RD;
    g_addr   = draw_addr;
    g_wdata  = '0;
    if (!draw_wins && rope_any) begin
      g_who    = pick ? W_R1 : W_R0;
      g_raw_op = pick ? rope_op[3:2] : rope_op[1:0];
      g_op     = (g_raw_op == 2'b11) ? OP_RD : g_raw_op;
      g_addr   = pick ? rope_addr[7:4] : rope_addr[3:0];
      g_wdata  = pick ? rope_wdata[63:32] : rope_wdata[31:0];
    end
  end

  always_comb begin
    state_d       = state_q;
    who_d         = who_q;
    op_d          = op_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    word_d        = word_q;
    cnt_d         = cnt_q;
    streak_d      = streak_q;
    rr_last_d     = rr_last_q;
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;
    ram_wren_d    = 1'b0;
    draw_ack_d    = 1'b0;
    rope_ack_d    = 2'b00;
    rdata_d       = '0;
    tas_ok_d      = 1'b0;
    res           = '0;
    res_ok        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (grant) begin
          who_d   = g_who;
          op_d    = g_op;
          addr_d  = g_addr;
          wdata_d = g_wdata;
          if (draw_wins) begin
            if (!rope_any) begin
              streak_d = '0;
            end else if (streak_q != SMAX) begin
              streak_d = streak_q + 1'b1;
            end
          end else begin
            streak_d  = '0;
            rr_last_d = pick;
          end
          if (g_addr >= quantity) begin
            state_d = S_DONE;
          end else begin
            state_d       = S_ISSUE;
            ram_address_d = g_addr;
            ram_wren_d    = (g_op == OP_WR);
            ram_data_d    = (g_op == OP_WR) ? g_wdata : '0;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          word_d = ram_q;
          if (op_q == OP_WR) begin
            state_d = S_DONE;
          end else if (op_q == OP_TAS && ram_q[1:0] == 2'b10) begin
            state_d       = S_TAS_WR;
            ram_address_d = addr_q;
            ram_wren_d    = 1'b1;
            ram_data_d    = ram_q | 32'h1;
          end else begin
            state_d = S_DONE;
            res     = ram_q;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_TAS_WR: begin
        state_d = S_DONE;
        res     = word_q | 32'h1;
        res_ok  = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Acks and result are registered on the way into DONE
    if (state_d == S_DONE) begin
      draw_ack_d = (who_d == W_DRAW);
      rope_ack_d = {who_d == W_R1, who_d == W_R0};
      rdata_d    = res;
      tas_ok_d   = res_ok;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      who_q         <= W_DRAW;
      op_q          <= OP_RD;
      addr_q        <= '0;
      wdata_q       <= '0;
      word_q        <= '0;
      cnt_q         <= '0;
      streak_q      <= '0;
      rr_last_q     <= 1'b1;
      draw_ack_q    <= 1'b0;
      rope_ack_q    <= 2'b00;
      rdata_q       <= '0;
      tas_ok_q      <= 1'b0;
      busy_q        <= 1'b0;
      ram_address_q <= '0;
      ram_data_q    <= '0;
      ram_wren_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      who_q         <= who_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      word_q        <= word_d;
      cnt_q         <= cnt_d;
      streak_q      <= streak_d;
      rr_last_q     <= rr_last_d;
      draw_ack_q    <= draw_ack_d;
      rope_ack_q    <= rope_ack_d;
      rdata_q       <= rdata_d;
      tas_ok_q      <= tas_ok_d;
      busy_q        <= busy_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      ram_wren_q    <= ram_wren_d;
    end
  end

  assign draw_ack    = draw_ack_q;
  assign rope_ack    = rope_ack_q;
  assign rdata       = rdata_q;
  assign tas_ok      = tas_ok_q;
  assign busy        = busy_q;
  assign ram_address = ram_address_q;
  assign ram_data    = ram_data_q;
  assign ram_wren    = ram_wren_q;

endmodule

// File: tb/tb_stone_ram_arbiter.sv
// Directed bench for stone_ram_arbiter with a 1-cycle synchronous
// RAM model and hand-computed expectations.
module tb_stone_ram_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  quantity;
  logic        draw_req;
  logic [3:0]  draw_addr;
  logic        draw_ack;
  logic [1:0]  rope_req;
  logic [3:0]  rope_op;
  logic [7:0]  rope_addr;
  logic [63:0] rope_wdata;
  logic [1:0]  rope_ack;
  logic [31:0] rdata;
  logic        tas_ok;
  logic        busy;
  logic [3:0]  ram_address;
  logic [31:0] ram_data;
  logic        ram_wren;
  logic [31:0] ram_q;

  logic [31:0] mem [16];
  logic        pl_en;
  logic [3:0]  pl_addr;
  logic [31:0] pl_data;
  logic        wren_seen;

  int checks = 0;
  int errors = 0;

  stone_ram_arbiter #(
    .DRAW_MAX_CONSEC(4),
    .RAM_LATENCY(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .quantity(quantity),
    .draw_req(draw_req),
    .draw_addr(draw_addr),
    .draw_ack(draw_ack),
    .rope_req(rope_req),
    .rope_op(rope_op),
    .rope_addr(rope_addr),
    .rope_wdata(rope_wdata),
    .rope_ack(rope_ack),
    .rdata(rdata),
    .tas_ok(tas_ok),
    .busy(busy),
    .ram_address(ram_address),
    .ram_data(ram_data),
    .ram_wren(ram_wren),
    .ram_q(ram_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  always @(negedge clock) begin
    if (ram_wren) wren_seen = 1'b1;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs;
    draw_req   = 1'b0;
    draw_addr  = '0;
    rope_req   = 2'b00;
    rope_op    = '0;
    rope_addr  = '0;
    rope_wdata = '0;
  endtask

  task automatic apply_reset;
    reset = 1'b1;
    clear_inputs();
    tick();
    reset = 1'b0;
  endtask

  task automatic preload(input logic [3:0] a, input logic [31:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  // n = cycles until the ack, -1 if it never came
  task automatic wait_ack(input int which, output int n);
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      if (which == 2) seen = draw_ack;
      else seen = rope_ack[which];
    end
    if (!seen) n = -1;
  endtask

  task automatic test_reset;
    quantity = 4'd8;
    pl_en = 1'b0;
    pl_addr = '0;
    pl_data = '0;
    clear_inputs();
    reset = 1'b1;
    #12;
    checks++;
    if ({draw_ack, rope_ack, tas_ok, busy, ram_wren} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 000000",
               {draw_ack, rope_ack, tas_ok, busy, ram_wren});
    end
    checks++;
    if ({rdata, ram_data, ram_address} !== 68'h0) begin
      errors++;
      $display("FAIL reset_buses: got %h required 0",
               {rdata, ram_data, ram_address});
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_read;
    int n;
    apply_reset();
    quantity = 4'd8;
    preload(4'd3, 32'hA5A5_0002);
    wren_seen = 1'b0;
    rope_req  = 2'b01;
    rope_op   = 4'b0000;
    rope_addr = 8'h03;
    wait_ack(0, n);
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL read_latency: got %0d required 3", n);
    end
    checks++;
    if (rdata !== 32'hA5A5_0002) begin
      errors++;
      $display("FAIL read_data: got %h required a5a50002", rdata);
    end
    rope_req = 2'b00;
    tick();
    checks++;
    if (wren_seen !== 1'b0) begin
      errors++;
      $display("FAIL read_no_wren: got %b required 0", wren_seen);
    end
  endtask

  task automatic test_tas;
    int n;
    apply_reset();
    preload(4'd5, 32'h0000_0002);
    rope_req  = 2'b11;
    rope_op   = 4'b1010;
    rope_addr = 8'h55;
    wait_ack(0, n);
    checks++;
    if (n !== 4 || tas_ok !== 1'b1 || rdata !== 32'h3 || rope_ack !== 2'b01) begin
      errors++;
      $display("FAIL tas_win: got n=%0d ok=%b rdata=%h ack=%b required 4 1 3 01",
               n, tas_ok, rdata, rope_ack);
    end
    rope_req = 2'b10;
    wait_ack(1, n);
    checks++;
    if (n !== 4 || tas_ok !== 1'b0 || rdata !== 32'h3) begin
      errors++;
      $display("FAIL tas_lose: got n=%0d ok=%b rdata=%h required 4 0 3",
               n, tas_ok, rdata);
    end
    rope_req = 2'b00;
    tick();
    checks++;
    if (mem[5] !== 32'h3) begin
      errors++;
      $display("FAIL tas_mem: got %h required 3", mem[5]);
    end
  endtask

  task automatic test_draw_streak;
    int seq[$];
    int exp_seq[6] = '{0, 0, 0, 0, 1, 0};
    logic both = 1'b0;
    logic [31:0] first_draw = '0;
    logic [31:0] rope_data = '0;
    apply_reset();
    preload(4'd3, 32'hA5A5_0002);
    preload(4'd4, 32'h1234_5678);
    draw_req  = 1'b1;
    draw_addr = 4'd3;
    rope_req  = 2'b10;
    rope_op   = 4'b0000;
    rope_addr = 8'h40;
    for (int c = 0; c < 80 && seq.size() < 6; c++) begin
      tick();
      if (draw_ack && rope_ack != 2'b00) both = 1'b1;
      if (draw_ack) begin
        if (seq.size() == 0) first_draw = rdata;
        seq.push_back(0);
      end
      if (rope_ack[1]) begin
        rope_data = rdata;
        seq.push_back(1);
        rope_req = 2'b00;
      end
    end
    draw_req = 1'b0;
    checks++;
    if (seq.size() !== 6) begin
      errors++;
      $display("FAIL streak_count: got %0d acks required 6", seq.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (seq[i] !== exp_seq[i]) begin
          errors++;
          $display("FAIL streak_order[%0d]: got %0d required %0d",
                   i, seq[i], exp_seq[i]);
        end
      end
    end
    checks++;
    if (first_draw !== 32'hA5A5_0002 || rope_data !== 32'h1234_5678) begin
      errors++;
      $display("FAIL streak_data: got %h/%h required a5a50002/12345678",
               first_draw, rope_data);
    end
    checks++;
    if (both !== 1'b0) begin
      errors++;
      $display("FAIL streak_one_hot: got %b required 0", both);
    end
    tick();
    tick();
    tick();
    tick();
  endtask

  task automatic test_out_of_range;
    int n;
    apply_reset();
    quantity = 4'd8;
    preload(4'd9, 32'hDEAD_BEEF);
    preload(4'd7, 32'h0000_0777);
    wren_seen  = 1'b0;
    rope_req   = 2'b01;
    rope_op    = 4'b0001;
    rope_addr  = 8'h09;
    rope_wdata = {32'h0, 32'h1111_1111};
    wait_ack(0, n);
    checks++;
    if (n !== 1 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL oor_write: got n=%0d rdata=%h required 1 0", n, rdata);
    end
    rope_req = 2'b00;
    tick();
    checks++;
    if (wren_seen !== 1'b0 || mem[9] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL oor_no_ram: got wren=%b mem=%h required 0 deadbeef",
               wren_seen, mem[9]);
    end
    rope_req  = 2'b10;
    rope_op   = 4'b1100;
    rope_addr = 8'h80;
    wait_ack(1, n);
    checks++;
    if (n !== 1 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL oor_edge: got n=%0d rdata=%h required 1 0", n, rdata);
    end
    rope_req = 2'b00;
    tick();
    rope_req  = 2'b10;
    rope_addr = 8'h70;
    wait_ack(1, n);
    checks++;
    if (n !== 3 || rdata !== 32'h0000_0777) begin
      errors++;
      $display("FAIL in_range_edge: got n=%0d rdata=%h required 3 777",
               n, rdata);
    end
    rope_req = 2'b00;
    tick();
  endtask

  task automatic test_back_to_back;
    int who[$];
    int tt[$];
    logic [31:0] dv[$];
    int exp_who[4] = '{0, 1, 0, 1};
    logic [31:0] exp_d[4] = '{32'h0101_0101, 32'h0202_0202,
                              32'h0101_0101, 32'h0202_0202};
    apply_reset();
    preload(4'd1, 32'h0101_0101);
    preload(4'd2, 32'h0202_0202);
    rope_req  = 2'b11;
    rope_op   = 4'b0000;
    rope_addr = 8'h21;
    for (int c = 1; c <= 60 && who.size() < 4; c++) begin
      tick();
      if (rope_ack[0]) begin
        who.push_back(0);
        tt.push_back(c);
        dv.push_back(rdata);
      end else if (rope_ack[1]) begin
        who.push_back(1);
        tt.push_back(c);
        dv.push_back(rdata);
      end
    end
    rope_req = 2'b00;
    checks++;
    if (who.size() !== 4) begin
      errors++;
      $display("FAIL rr_count: got %0d acks required 4", who.size());
    end else begin
      checks++;
      if (tt[0] !== 3) begin
        errors++;
        $display("FAIL rr_first: got cycle %0d required 3", tt[0]);
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (who[i] !== exp_who[i] || dv[i] !== exp_d[i]) begin
          errors++;
          $display("FAIL rr_order[%0d]: got rope%0d %h required rope%0d %h",
                   i, who[i], dv[i], exp_who[i], exp_d[i]);
        end
        if (i > 0) begin
          checks++;
          if (tt[i] - tt[i-1] !== 4) begin
            errors++;
            $display("FAIL rr_spacing[%0d]: got %0d required 4",
                     i, tt[i] - tt[i-1]);
          end
        end
      end
    end
    tick();
    tick();
  endtask

  task automatic test_reset_in_tas;
    int n;
    apply_reset();
    preload(4'd6, 32'h0000_0002);
    rope_req  = 2'b01;
    rope_op   = 4'b0010;
    rope_addr = 8'h06;
    tick();
    tick();
    tick();
    checks++;
    if (ram_wren !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL tas_wr_reach: got wren=%b busy=%b required 1 1",
               ram_wren, busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (ram_wren !== 1'b0 || busy !== 1'b0 || rope_ack !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset: got wren=%b busy=%b ack=%b required 0 0 00",
               ram_wren, busy, rope_ack);
    end
    @(posedge clock);
    #1;
    checks++;
    if (mem[6] !== 32'h2 || rope_ack !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset_mem: got mem=%h ack=%b required 2 00",
               mem[6], rope_ack);
    end
    reset = 1'b0;
    wait_ack(0, n);
    checks++;
    if (n !== 4 || tas_ok !== 1'b1 || rdata !== 32'h3) begin
      errors++;
      $display("FAIL after_reset_tas: got n=%0d ok=%b rdata=%h required 4 1 3",
               n, tas_ok, rdata);
    end
    rope_req = 2'b00;
    tick();
    checks++;
    if (mem[6] !== 32'h3) begin
      errors++;
      $display("FAIL after_reset_mem: got %h required 3", mem[6]);
    end
  endtask

  initial begin
    wren_seen = 1'b0;
    test_reset();
    test_read();
    test_tas();
    test_draw_streak();
    test_out_of_range();
    test_back_to_back();
    test_reset_in_tas();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stone_ram_arbiter.md
Name: stone_ram_arbiter

Overview:
Shares the single-port 16x32 stone RAM between the stone drawer (read-only) and two rope controllers (one per player in two-player mode). Each access is serialized through a small FSM. The FSM also provides an atomic test-and-set, so that two ropes cannot both claim the same stone. The block sits between the controllers and the RAM instance and replaces ad-hoc address muxing.

Parameters:
DRAW_MAX_CONSEC, 4, max consecutive drawer grants while any rope request is pending
RAM_LATENCY, 1, RAM read latency in cycles (q valid this many cycles after address is driven); supported values 1..3

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
quantity  in  4  number of valid stone entries; addresses >= quantity are out of range
draw_req  in  1  drawer read request, held until draw_ack
draw_addr  in  4  drawer read address
draw_ack  out  1  one-cycle completion pulse to drawer
rope_req  in  2  rope request per player, held until matching rope_ack bit
rope_op  in  4  2 bits per rope: 00 read, 01 write, 10 test-and-set, 11 treated as read
rope_addr  in  8  4 bits per rope
rope_wdata  in  64  32 bits per rope (write data)
rope_ack  out  2  one-cycle completion pulse per rope
rdata  out  32  read data; valid only in the ack cycle
tas_ok  out  1  test-and-set succeeded; valid only in the ack cycle
busy  out  1  high whenever FSM is not IDLE
ram_address  out  4  to RAM
ram_data  out  32  to RAM
ram_wren  out  1  to RAM

Behaviour:
- Reset (async): FSM to IDLE; all outputs 0; rr_last=1 (rope0 wins the first tie); draw_streak=0. Reset mid-transaction aborts it: no ack, ram_wren drops immediately, no RAM write completes after reset assertion.
- States: IDLE, ISSUE, WAIT, TAS_WR, DONE.
- IDLE: if any request is pending, choose a winner, latch its op/addr/wdata, go to ISSUE; else stay.
- Winner selection: drawer wins unless draw_streak==DRAW_MAX_CONSEC and a rope is pending. Between ropes, if both request, grant the rope != rr_last; if one requests, grant it. rr_last updates on every rope grant.
- draw_streak: +1 on a drawer grant while rope_req!=0, saturating at DRAW_MAX_CONSEC. Cleared on any rope grant, and on a drawer grant with rope_req==0.
- Out of range (addr >= quantity): skip the RAM entirely. Go IDLE->DONE directly with rdata=0 and tas_ok=0.
- ISSUE: drive ram_address=addr for one cycle; ram_wren=1 and ram_data=wdata only for write. Go to WAIT.
- WAIT: hold RAM_LATENCY cycles; capture ram_q on the last cycle.
  - Read: go to DONE with rdata=captured word.
  - Write: go to DONE with rdata=0.
  - Test-and-set: if q[1]==1 and q[0]==0 (visible and not moving), go to TAS_WR. Otherwise go to DONE with tas_ok=0 and rdata=q.
- TAS_WR: ram_address=addr, ram_wren=1, ram_data=q|32'h1, for one cycle. Go to DONE with tas_ok=1 and rdata=q|1.
- DONE: pulse the winner's ack for one cycle with rdata/tas_ok; go to IDLE. Only one ack bit is ever high at a time.
- Latency, request sampled in IDLE at cycle 0, RAM_LATENCY=1:
  - in-range read or write: ack at cycle 3
  - successful test-and-set: ack at cycle 4
  - out-of-range: ack at cycle 1
- Back-to-back: a requester may hold req across its ack and is re-arbitrated in the next IDLE. Minimum spacing of in-range grants is 4 cycles.
- Requests changing while not granted: ignored until sampled in IDLE. Inputs of the granted requester are not re-read after latching.
- ram_wren is 0 in all states other than ISSUE-for-write and TAS_WR.

Test Plan:
- Reset, quantity=8, RAM[3]=32'hA5A5_0002, rope0 read addr 3 -> rope_ack[0] at cycle 3, rdata=32'hA5A5_0002; ram_wren never 1.
- rope0 and rope1 both issue test-and-set on addr 5, RAM[5]=32'h0000_0002 -> rope0 acked first with tas_ok=1 and rdata=32'h3; rope1 then acked with tas_ok=0 and rdata=32'h3; RAM[5]=32'h3 after.
- draw_req held continuously with rope1 read pending, DRAW_MAX_CONSEC=4 -> exactly 4 draw_acks, then rope1_ack, then the drawer resumes.
- rope0 write addr 9 with quantity=8 -> rope_ack[0] at cycle 1, rdata=0, no RAM access.
- Both ropes request reads continuously -> acks alternate rope0, rope1, rope0, ...
- Assert reset during TAS_WR -> ram_wren=0 in the same cycle, no ack, busy=0; the next request completes normally.
